// File: rtl/ram31_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : ram31_burst_reader_if
// Summary  : RAM read port plus valid/ready output stream of the 31Kx18 bank
//            burst reader. The master side is the reader; the slave side is
//            the RAM read port together with the stream consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface ram31_burst_reader_if;
    logic [14:0] ram_addr;
    logic        ram_rd;
    logic [17:0] ram_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [17:0] m_data;
    logic        m_last;

    modport master (
        output ram_addr, ram_rd, m_valid, m_data, m_last,
        input  ram_rdata, m_ready
    );

    modport slave (
        input  ram_addr, ram_rd, m_valid, m_data, m_last,
        output ram_rdata, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/ram31_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram31_burst_reader
// Summary  : Sequential burst reader for the 31Kx18 block-RAM bank. Issues
//            credit-limited reads, buffers returning words in a small FIFO
//            and presents them on a valid/ready stream with m_last.
// Options  : define RAM31_RD_CHKSUM_EN to add the chksum output (18-bit
//            running sum of words popped in the current burst).
// Revision : 1.0 - initial release
// ============================================================================
module ram31_burst_reader #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WORDS = 31744
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [14:0] start_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
`ifdef RAM31_RD_CHKSUM_EN
    output logic [17:0] chksum,
`endif
    ram31_burst_reader_if.master bus
);

    localparam int              c_pw         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [16:0]     c_addr_words = 17'(ADDR_WORDS);
    localparam logic [14:0]     c_last_addr  = 15'(ADDR_WORDS - 1);
    localparam logic [15:0]     c_depth      = 16'(FIFO_DEPTH);
    localparam logic [c_pw-1:0] c_ptr_last   = c_pw'(FIFO_DEPTH - 1);
    localparam logic [c_pw-1:0] c_ptr_one    = c_pw'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [14:0]       r_cur;        // next address to issue
    logic [15:0]       r_remain;     // reads still to issue
    logic [15:0]       r_inflight;   // issued but not yet popped
    logic              r_rd;
    logic              r_rd_last;
    logic [14:0]       r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [RD_LAT-1:0] r_pipe_last;
    logic [18:0]       r_mem [FIFO_DEPTH];   // {last, data}
    logic [c_pw-1:0]   r_wp;
    logic [c_pw-1:0]   r_rp;
    logic [15:0]       r_fcount;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_credit;
    logic              w_issue;
    logic [18:0]       w_head;
    logic [14:0]       w_next_cur;
    logic [14:0]       w_start_next;

    assign w_start_ok   = (len != 16'd0) && ({1'b0, len} <= c_addr_words)
                          && ({2'b00, start_addr} < c_addr_words);
    assign w_accept     = (r_state == S_IDLE) && start && w_start_ok;
    assign w_pop        = (r_fcount != 16'd0) && bus.m_ready;
    assign w_push       = r_pipe_vld[RD_LAT-1];
    // A pop in this cycle frees a credit immediately, which is what keeps
    // one word per cycle flowing when the loop needs exactly RD_LAT+2 credits.
    assign w_credit     = (r_inflight < c_depth) || w_pop;
    // The first read goes out on the accepting edge so data can appear
    // RD_LAT+1 cycles after start.
    assign w_issue      = w_accept || ((r_state == S_RUN) && w_credit);
    assign w_head       = r_mem[r_rp];
    assign w_next_cur   = (r_cur == c_last_addr) ? 15'd0 : r_cur + 15'd1;
    assign w_start_next = (start_addr == c_last_addr) ? 15'd0 : start_addr + 15'd1;

    assign bus.ram_addr = r_addr;
    assign bus.ram_rd   = r_rd;
    assign bus.m_valid  = (r_fcount != 16'd0);
    assign bus.m_data   = w_head[17:0];
    assign bus.m_last   = (r_fcount != 16'd0) && w_head[18];
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

    // Control FSM: request checking, read issue with address wrap, completion.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_remain  <= '0;
            r_rd      <= 1'b0;
            r_rd_last <= 1'b0;
            r_addr    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_rd      <= 1'b0;
            r_rd_last <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_err    <= 1'b0;
                            r_busy   <= 1'b1;
                            r_rd     <= 1'b1;
                            r_addr   <= start_addr;
                            r_cur    <= w_start_next;
                            r_remain <= len - 16'd1;
                            if (len == 16'd1) begin
                                r_rd_last <= 1'b1;
                                r_state   <= S_DRAIN;
                            end else begin
                                r_state   <= S_RUN;
                            end
                        end else begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_credit && (r_remain != 16'd0)) begin
                        r_rd     <= 1'b1;
                        r_addr   <= r_cur;
                        r_cur    <= w_next_cur;
                        r_remain <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_rd_last <= 1'b1;
                            r_state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head[18]) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Credit counter: reads in flight plus words waiting in the FIFO.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (w_issue && !w_pop) begin
            r_inflight <= r_inflight + 16'd1;
        end else if (!w_issue && w_pop) begin
            r_inflight <= r_inflight - 16'd1;
        end
    end

    // Read-latency tracker: a valid bit leaving the last stage marks ram_rdata.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_vld[0]  <= r_rd;
            r_pipe_last[0] <= r_rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    // Output FIFO: storage, pointers and occupancy.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp     <= '0;
            r_rp     <= '0;
            r_fcount <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= {r_pipe_last[RD_LAT-1], bus.ram_rdata};
                r_wp        <= (r_wp == c_ptr_last) ? '0 : r_wp + c_ptr_one;
            end
            if (w_pop) begin
                r_rp <= (r_rp == c_ptr_last) ? '0 : r_rp + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_fcount <= r_fcount + 16'd1;
            end else if (!w_push && w_pop) begin
                r_fcount <= r_fcount - 16'd1;
            end
        end
    end

    a_fifo_no_overflow: assert property (@(posedge mclk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_fcount == c_depth)));

`ifdef RAM31_RD_CHKSUM_EN
    logic [17:0] r_chksum;
    assign chksum = r_chksum;

    // Running sum of popped words, restarted by each accepted request.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_chksum <= '0;
        end else if (w_accept) begin
            r_chksum <= '0;
        end else if (w_pop) begin
            r_chksum <= r_chksum + w_head[17:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram31_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram31_burst_reader
// Summary  : Self-checking bench for ram31_burst_reader with a behavioural
//            RAM and a reference model of the expected word sequence.
// Options  : RAM31_RD_CHKSUM_EN enables the chksum checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram31_burst_reader;

    localparam int RD_LAT     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_WORDS = 31744;

    logic        mclk       = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic [14:0] start_addr = '0;
    logic [15:0] len        = '0;
    logic        busy;
    logic        done;
    logic        err;
`ifdef RAM31_RD_CHKSUM_EN
    logic [17:0] chksum;
`endif

    int checks   = 0;
    int failures = 0;

    ram31_burst_reader_if bus();

    ram31_burst_reader #(
        .RD_LAT    (RD_LAT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_WORDS(ADDR_WORDS)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
`ifdef RAM31_RD_CHKSUM_EN
        .chksum    (chksum),
`endif
        .bus       (bus)
    );

    always #5 mclk = ~mclk;

    // Behavioural RAM with RD_LAT cycles of read latency.
    logic [17:0] mem [32768];
    logic [17:0] lat [RD_LAT];
    always @(posedge mclk) begin
        lat[0] <= mem[bus.ram_addr];
        for (int i = 1; i < RD_LAT; i++) lat[i] <= lat[i-1];
    end
    assign bus.ram_rdata = lat[RD_LAT-1];

    // Port monitor: records issues, pops, stalls and done pulses.
    int          cyc = 0, n_iss = 0, n_done = 0, n_vld = 0;
    int          outst = 0, max_out = 0, stall_viol = 0;
    logic [14:0] iss_q[$];
    logic [17:0] dat_q[$];
    logic        last_q[$];
    int          pop_cyc_q[$];
    int          rise_q[$];
    logic        prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
    logic [17:0] prev_data = '0;
`ifdef RAM31_RD_CHKSUM_EN
    logic [17:0] chk_at_done = '0;
`endif

    always @(negedge mclk) begin
        cyc++;
        if (!rst_n) outst = 0;
        if (bus.ram_rd === 1'b1) begin
            n_iss++; outst++; iss_q.push_back(bus.ram_addr);
        end
        if (outst > max_out) max_out = outst;
        if (prev_stall && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last))
            stall_viol++;
        if (bus.m_valid === 1'b1 && !prev_valid) rise_q.push_back(cyc);
        if (bus.m_valid === 1'b1) n_vld++;
        if (done === 1'b1) begin
            n_done++;
`ifdef RAM31_RD_CHKSUM_EN
            chk_at_done = chksum;
`endif
        end
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            dat_q.push_back(bus.m_data); last_q.push_back(bus.m_last);
            pop_cyc_q.push_back(cyc); outst--;
        end
        prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
        prev_valid = (bus.m_valid === 1'b1);
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
    end

    // Snapshots of monitor state taken when a burst is launched.
    int b_iss, b_pop, b_done, b_vld, b_rise, acc_cyc;

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
        return ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic [17:0] exp_word(input int a, input int i);
        return mem[(a + i) % ADDR_WORDS];
    endfunction

    // Launches one request and waits for its done pulse (bounded).
    task automatic run_burst(input int a, input int n, input int mode,
                             input int restart_at, input int budget, output bit to);
        @(posedge mclk); #1;
        b_iss = n_iss; b_pop = dat_q.size(); b_done = n_done; b_vld = n_vld; b_rise = rise_q.size();
        start = 1'b1; start_addr = 15'(a); len = 16'(n); bus.m_ready = rdy(mode, 0);
        @(posedge mclk); acc_cyc = cyc + 1; #1;
        start = 1'b0;
        to = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            bus.m_ready = rdy(mode, c);
            if (c == restart_at) begin
                start = 1'b1; start_addr = 15'd31744; len = 16'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge mclk); #1;
            if (n_done > b_done) begin to = 1'b0; break; end
        end
        start = 1'b0;
        bus.m_ready = 1'b1;
        repeat (4) @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.m_ready = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000", {busy, done, err});
        end
        checks++;
        if ({bus.ram_rd, bus.m_valid, bus.m_last} !== 3'b000) begin
            failures++; $display("FAIL reset_bus got=%b exp=000", {bus.ram_rd, bus.m_valid, bus.m_last});
        end
        checks++;
        if (bus.ram_addr !== 15'd0 || bus.m_data !== 18'd0) begin
            failures++; $display("FAIL reset_addr_data got=%0h/%0h exp=0/0", bus.ram_addr, bus.m_data);
        end
`ifdef RAM31_RD_CHKSUM_EN
        checks++;
        if (chksum !== 18'd0) begin failures++; $display("FAIL reset_chksum got=%0h exp=0", chksum); end
`endif
        @(negedge mclk); rst_n = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
    endtask

    task automatic test_basic();
        bit to;
        for (int i = 0; i < 10; i++) mem[i] = 18'(i + 'h100);
        run_burst(0, 10, 0, -1, 200, to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
        checks++;
        if (dat_q.size() - b_pop != 10) begin
            failures++; $display("FAIL basic_count got=%0d exp=10", dat_q.size() - b_pop);
        end
        for (int i = 0; i < 10 && b_pop + i < dat_q.size(); i++) begin
            checks++;
            if (dat_q[b_pop+i] !== 18'(i + 'h100) || last_q[b_pop+i] !== (i == 9)) begin
                failures++;
                $display("FAIL basic_word%0d got=%0h/%b exp=%0h/%b", i, dat_q[b_pop+i], last_q[b_pop+i], i + 'h100, i == 9);
            end
        end
        checks++;
        if (n_done - b_done != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_done got=%0d/busy%b exp=1/busy0", n_done - b_done, busy);
        end
        checks++;
        if (rise_q.size() <= b_rise || rise_q[b_rise] - acc_cyc != RD_LAT + 1) begin
            failures++; $display("FAIL basic_latency got=%0d exp=%0d",
                                 (rise_q.size() > b_rise) ? rise_q[b_rise] - acc_cyc : -1, RD_LAT + 1);
        end
        checks++;
        if (dat_q.size() - b_pop == 10 && pop_cyc_q[b_pop+9] - pop_cyc_q[b_pop] != 9) begin
            failures++; $display("FAIL basic_throughput got=%0d exp=9", pop_cyc_q[b_pop+9] - pop_cyc_q[b_pop]);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        run_burst(0, 10, 1, -1, 300, to);
        checks++;
        if (to || dat_q.size() - b_pop != 10) begin
            failures++; $display("FAIL bp_count got=%0d exp=10", dat_q.size() - b_pop);
        end
        for (int i = 0; i < 10 && b_pop + i < dat_q.size(); i++) begin
            checks++;
            if (dat_q[b_pop+i] !== 18'(i + 'h100) || last_q[b_pop+i] !== (i == 9)) begin
                failures++;
                $display("FAIL bp_word%0d got=%0h/%b exp=%0h/%b", i, dat_q[b_pop+i], last_q[b_pop+i], i + 'h100, i == 9);
            end
        end
        checks++;
        if (stall_viol != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        checks++;
        if (max_out > FIFO_DEPTH) begin failures++; $display("FAIL bp_occupancy got=%0d exp<=%0d", max_out, FIFO_DEPTH); end
        checks++;
        if (n_done - b_done != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", n_done - b_done); end
    endtask

    task automatic test_wrap();
        bit to;
        int exp_a [4] = '{31742, 31743, 0, 1};
        run_burst(31742, 4, 0, -1, 100, to);
        checks++;
        if (to || n_iss - b_iss != 4 || dat_q.size() - b_pop != 4) begin
            failures++; $display("FAIL wrap_count got=%0d/%0d exp=4/4", n_iss - b_iss, dat_q.size() - b_pop);
        end
        for (int i = 0; i < 4 && b_iss + i < iss_q.size() && b_pop + i < dat_q.size(); i++) begin
            checks++;
            if (iss_q[b_iss+i] !== 15'(exp_a[i]) || dat_q[b_pop+i] !== mem[exp_a[i]]) begin
                failures++;
                $display("FAIL wrap_word%0d got=%0d:%0h exp=%0d:%0h", i, iss_q[b_iss+i], dat_q[b_pop+i], exp_a[i], mem[exp_a[i]]);
            end
        end
    endtask

    task automatic test_invalid();
        bit to;
        int a, n;
        for (int k = 0; k < 3; k++) begin
            a = (k == 2) ? 31744 : 0;
            n = (k == 0) ? 0 : ((k == 1) ? 31745 : 1);
            run_burst(a, n, 0, -1, 20, to);
            checks++;
            if (to || err !== 1'b1 || n_done - b_done != 1) begin
                failures++; $display("FAIL invalid%0d_err got=err%b/done%0d exp=err1/done1", k, err, n_done - b_done);
            end
            checks++;
            if (n_iss != b_iss || n_vld != b_vld || busy !== 1'b0) begin
                failures++; $display("FAIL invalid%0d_quiet got=rd%0d/vld%0d exp=0/0", k, n_iss - b_iss, n_vld - b_vld);
            end
        end
    endtask

    task automatic test_restart_ignored();
        bit to;
        int a;
        a = $urandom_range(0, ADDR_WORDS - 1);
        run_burst(a, 8, 0, 3, 100, to);
        checks++;
        if (to || dat_q.size() - b_pop != 8 || n_done - b_done != 1) begin
            failures++; $display("FAIL restart_count got=%0d/%0d exp=8/1", dat_q.size() - b_pop, n_done - b_done);
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL restart_err got=%b exp=0", err); end
        for (int i = 0; i < 8 && b_pop + i < dat_q.size(); i++) begin
            checks++;
            if (dat_q[b_pop+i] !== exp_word(a, i) || last_q[b_pop+i] !== (i == 7)) begin
                failures++; $display("FAIL restart_word%0d got=%0h exp=%0h", i, dat_q[b_pop+i], exp_word(a, i));
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int a, n, bad;
        logic [17:0] sum;
        for (int b = 0; b < 6; b++) begin
            a = (b % 2 == 1) ? ADDR_WORDS - 1 - $urandom_range(0, 19) : $urandom_range(0, ADDR_WORDS - 1);
            n = $urandom_range(1, 40);
            run_burst(a, n, 2, -1, 600, to);
            checks++;
            if (to || dat_q.size() - b_pop != n || n_done - b_done != 1 || busy !== 1'b0) begin
                failures++; $display("FAIL rand%0d_count got=%0d/%0d exp=%0d/1", b, dat_q.size() - b_pop, n_done - b_done, n);
            end
            bad = 0; sum = '0;
            for (int i = 0; i < n; i++) begin
                sum = sum + exp_word(a, i);
                if (b_pop + i < dat_q.size())
                    if (dat_q[b_pop+i] !== exp_word(a, i) || last_q[b_pop+i] !== (i == n - 1)) bad++;
            end
            checks++;
            if (bad != 0) begin failures++; $display("FAIL rand%0d_data got=%0d_bad exp=0_bad (a=%0d n=%0d)", b, bad, a, n); end
`ifdef RAM31_RD_CHKSUM_EN
            checks++;
            if (chk_at_done !== sum) begin failures++; $display("FAIL rand%0d_chksum got=%0h exp=%0h", b, chk_at_done, sum); end
`endif
        end
        checks++;
        if (stall_viol != 0 || max_out > FIFO_DEPTH) begin
            failures++; $display("FAIL rand_stream got=stall%0d/occ%0d exp=0/<=%0d", stall_viol, max_out, FIFO_DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        @(posedge mclk); #1;
        b_pop = dat_q.size(); b_done = n_done;
        start = 1'b1; start_addr = 15'd500; len = 16'd20; bus.m_ready = 1'b1;
        @(posedge mclk); #1;
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge mclk); #1;
            if (dat_q.size() - b_pop >= 3) break;
        end
        @(posedge mclk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, bus.ram_rd, bus.m_valid, bus.m_last} !== 6'd0 ||
            bus.ram_addr !== 15'd0 || bus.m_data !== 18'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%0h/%0h exp=0/0/0",
                     {busy, done, err, bus.ram_rd, bus.m_valid, bus.m_last}, bus.ram_addr, bus.m_data);
        end
`ifdef RAM31_RD_CHKSUM_EN
        checks++;
        if (chksum !== 18'd0) begin failures++; $display("FAIL midreset_chksum got=%0h exp=0", chksum); end
`endif
        repeat (2) @(posedge mclk);
        @(negedge mclk); rst_n = 1'b1;
        checks++;
        if (n_done != b_done) begin failures++; $display("FAIL midreset_nodone got=%0d exp=0", n_done - b_done); end
        run_burst(7, 5, 1, -1, 100, to);
        checks++;
        if (to || n_iss - b_iss != 5 || dat_q.size() - b_pop != 5 || n_done - b_done != 1) begin
            failures++; $display("FAIL postreset_count got=%0d/%0d exp=5/5", n_iss - b_iss, dat_q.size() - b_pop);
        end
        for (int i = 0; i < 5 && b_pop + i < dat_q.size(); i++) begin
            checks++;
            if (dat_q[b_pop+i] !== exp_word(7, i)) begin
                failures++; $display("FAIL postreset_word%0d got=%0h exp=%0h", i, dat_q[b_pop+i], exp_word(7, i));
            end
        end
    endtask

`ifdef RAM31_RD_CHKSUM_EN
    task automatic test_chksum();
        bit to;
        mem[100] = 18'h3FFFF; mem[101] = 18'd1; mem[102] = 18'd2; mem[103] = 18'd3;
        run_burst(100, 4, 0, -1, 100, to);
        checks++;
        if (to || chk_at_done !== 18'h00005) begin failures++; $display("FAIL chksum_wrap got=%0h exp=5", chk_at_done); end
        checks++;
        if (chksum !== 18'h00005) begin failures++; $display("FAIL chksum_hold got=%0h exp=5", chksum); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 18'($urandom);
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_invalid();
        test_restart_ignored();
        test_random();
        test_reset_mid();
`ifdef RAM31_RD_CHKSUM_EN
        test_chksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
